scan_chain_loader: RTL and testbench



---
 rtl/scan_chain_loader.sv | 146 ++++++++++++++
 tb/tb_scan_chain_loader.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_loader.sv
// -----------------------------------------------------------------------------
// scan_chain_loader
//
// Initiator end of the memory bank's serial scan chain. A program image
// arrives as bytes over a valid/ready port and is shifted MSB first into the
// chain through scan_in. On the same clock edges, the bits falling out of
// scan_out are collected and returned as readback bytes. Those bytes are
// assembled MSB first, so the first bit out lands in rd_data[7]. This one
// pass therefore serves both for program load and for state dump.
//
// Each byte costs one handshake cycle plus eight shift cycles. scan_enable
// is low between bytes, and stays low for as long as the host stalls, so
// the chain holds its contents while waiting.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   start        one-cycle request to begin a full-chain pass (IDLE only)
//   abort        terminate the pass and return to IDLE
//   byte_in      next image byte
//   byte_valid   byte_in is valid
//   byte_ready   loader accepts byte_in this cycle
//   rd_data      captured readback byte
//   rd_valid     one-cycle strobe qualifying rd_data (no backpressure)
//   scan_enable  to memory bank scan_enable
//   scan_in      to memory bank scan_in
//   scan_out     from memory bank scan_out
//   busy         high while a pass is in progress
//   done         one-cycle pulse after CHAIN_LEN bits have shifted
// -----------------------------------------------------------------------------
module scan_chain_loader #(
  parameter int CHAIN_LEN = 256,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       scan_enable,
  output logic       scan_in,
  input  logic       scan_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BYTE,
    SHIFT,
    DONE
  } state_t;

  // Value of the total counter on the edge that shifts the final chain bit.
  // It is compared before the increment.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

  state_t           state;
  logic [7:0]       tx;
  logic [7:0]       rx;
  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] total_cnt;

  // These outputs are decoded purely from registered state, so they change
  // only on clock edges.
  assign scan_enable = (state == SHIFT);
  assign scan_in     = (state == SHIFT) ? tx[7] : 1'b0;
  assign byte_ready  = (state == WAIT_BYTE);
  assign busy        = (state != IDLE);

  // Main sequencer. rd_valid and done default low every cycle, which makes
  // them single-cycle strobes. abort takes priority over every state
  // transition and suppresses the strobes for a byte that did not complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 8'h00;
      rx        <= 8'h00;
      bit_cnt   <= 3'd0;
      total_cnt <= '0;
      rd_data   <= 8'h00;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        bit_cnt   <= 3'd0;
        total_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= WAIT_BYTE;
              total_cnt <= '0;
            end
          end

          WAIT_BYTE: begin
            if (byte_valid) begin
              tx      <= byte_in;
              bit_cnt <= 3'd0;
              state   <= SHIFT;
            end
          end

          SHIFT: begin
            // scan_out is sampled on the same edge on which the chain
            // advances, so rx sees the bit that was presented before the
            // shift.
            tx        <= {tx[6:0], 1'b0};
            rx        <= {rx[6:0], scan_out};
            bit_cnt   <= bit_cnt + 3'd1;
            total_cnt <= total_cnt + CNT_W'(1);
            if (bit_cnt == 3'd7) begin
              rd_data  <= {rx[6:0], scan_out};
              rd_valid <= 1'b1;
              if (total_cnt == LAST_BIT) begin
                // On the final byte, the readback strobe and done are
                // asserted in the same cycle.
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= WAIT_BYTE;
              end
            end
          end

          DONE: begin
            state <= IDLE;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_chain_loader.sv
// -----------------------------------------------------------------------------
// tb_scan_chain_loader
//
// Directed bench for scan_chain_loader with CHAIN_LEN = 16. The memory bank
// is modelled as a 16-bit serial delay line: scan_out is its MSB, and it
// shifts in scan_in on every clock edge at which scan_enable is high.
// -----------------------------------------------------------------------------
module tb_scan_chain_loader;

  localparam int CHAIN_LEN = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       scan_enable;
  logic       scan_in;
  logic       scan_out;
  logic       busy;
  logic       done;

  int checks = 0;
  int fails  = 0;

  // Chain model.
  logic [15:0] chain;
  logic        chain_load = 1'b0;
  logic [15:0] chain_preset = 16'h0000;

  // Observation counters, sampled on the falling edge.
  int         se_cycles  = 0;
  int         rv_count   = 0;
  int         done_count = 0;
  int         both_count = 0;
  logic [7:0] rd_log[$];

  // Set by do_load when scan_enable or byte_ready misbehaves during a
  // host stall.
  int gap_bad;

  always #5 clk = ~clk;

  scan_chain_loader #(.CHAIN_LEN(CHAIN_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .scan_enable(scan_enable),
    .scan_in    (scan_in),
    .scan_out   (scan_out),
    .busy       (busy),
    .done       (done)
  );

  assign scan_out = chain[15];

  always @(posedge clk) begin
    if (chain_load) chain <= chain_preset;
    else if (scan_enable) chain <= {chain[14:0], scan_in};
  end

  always @(negedge clk) begin
    if (scan_enable) se_cycles++;
    if (rd_valid) begin
      rv_count++;
      rd_log.push_back(rd_data);
    end
    if (done) done_count++;
    if (rd_valid && done) both_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preset_chain(input logic [15:0] v);
    chain_preset = v;
    chain_load   = 1'b1;
    tick();
    chain_load   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok         = 1'b0;
    byte_in    = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (byte_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int d0;
    d0 = done_count;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done_count != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Full two-byte pass, with an optional host stall before the second byte.
  task automatic do_load(input logic [7:0] b0, input logic [7:0] b1,
                         input int gap, output bit ok);
    bit ok0, ok1, ok2, okr;
    gap_bad = 0;
    okr     = 1'b1;
    pulse_start();
    send_byte(b0, ok0);
    if (gap > 0) begin
      okr = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (byte_ready) begin
          okr = 1'b1;
          break;
        end
        tick();
      end
      for (int i = 0; i < gap; i++) begin
        if (scan_enable !== 1'b0 || byte_ready !== 1'b1) gap_bad++;
        tick();
      end
    end
    send_byte(b1, ok1);
    wait_done(ok2);
    ok = ok0 & ok1 & ok2 & okr;
  endtask

  task automatic test_reset();
    int d0;
    bit ok;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, byte_ready, scan_enable, scan_in, rd_valid, done} !== 6'b0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got %b expected 000000",
               {busy, byte_ready, scan_enable, scan_in, rd_valid, done});
    end
    checks++;
    if (rd_data !== 8'h00) begin
      fails++;
      $display("[TB] FAIL reset_rd_data: got %h expected 00", rd_data);
    end
    // Reset in the middle of a shift.
    d0 = done_count;
    pulse_start();
    send_byte(8'hFF, ok);
    tick();
    tick();
    tick();
    checks++;
    if (scan_enable !== 1'b1 || !ok) begin
      fails++;
      $display("[TB] FAIL reset_pre_shift: got scan_enable=%b ok=%0d expected 1 1",
               scan_enable, ok);
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, byte_ready, scan_enable, rd_valid, done} !== 5'b0) begin
      fails++;
      $display("[TB] FAIL reset_mid_shift: got %b expected 00000",
               {busy, byte_ready, scan_enable, rd_valid, done});
    end
    tick();
    checks++;
    if (done_count != d0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_no_done: got done_delta=%0d busy=%b expected 0 0",
               done_count - d0, busy);
    end
  endtask

  // Shared result check for a 0x1234-preloaded chain and a two-byte load.
  task automatic test_loopback_case(input string tag, input logic [7:0] b0,
                                    input logic [7:0] b1, input int gap);
    int n0, se0, rv0, d0, bo0;
    bit ok;
    preset_chain(16'h1234);
    n0  = rd_log.size();
    se0 = se_cycles;
    rv0 = rv_count;
    d0  = done_count;
    bo0 = both_count;
    do_load(b0, b1, gap, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL %s_timeout: got ok=0 expected ok=1", tag);
    end
    checks++;
    if (rv_count - rv0 != 2) begin
      fails++;
      $display("[TB] FAIL %s_rd_count: got %0d expected 2", tag, rv_count - rv0);
    end
    checks++;
    if (rd_log.size() < n0 + 2 || rd_log[n0] !== 8'h12 || rd_log[n0+1] !== 8'h34) begin
      fails++;
      $display("[TB] FAIL %s_rd_data: got %p expected 12 34", tag, rd_log);
    end
    checks++;
    if (chain !== {b0, b1}) begin
      fails++;
      $display("[TB] FAIL %s_chain: got %h expected %h", tag, chain, {b0, b1});
    end
    checks++;
    if (done_count - d0 != 1 || both_count - bo0 != 1) begin
      fails++;
      $display("[TB] FAIL %s_done: got done=%0d both=%0d expected 1 1",
               tag, done_count - d0, both_count - bo0);
    end
    checks++;
    if (se_cycles - se0 != 16) begin
      fails++;
      $display("[TB] FAIL %s_shift_cycles: got %0d expected 16", tag, se_cycles - se0);
    end
    checks++;
    if (busy !== 1'b0 || byte_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s_idle_after: got busy=%b ready=%b expected 0 0",
               tag, busy, byte_ready);
    end
  endtask

  task automatic test_loopback();
    test_loopback_case("loopback", 8'hA5, 8'h3C, 0);
  endtask

  task automatic test_stall();
    test_loopback_case("stall", 8'hA5, 8'h3C, 20);
    checks++;
    if (gap_bad != 0) begin
      fails++;
      $display("[TB] FAIL stall_gap: got %0d bad cycles expected 0", gap_bad);
    end
  endtask

  task automatic test_abort();
    int rv0, d0;
    bit ok0, ok1;
    preset_chain(16'h1234);
    rv0 = rv_count;
    d0  = done_count;
    pulse_start();
    send_byte(8'hA5, ok0);
    send_byte(8'h3C, ok1);
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, scan_enable, byte_ready} !== 3'b000 || !ok0 || !ok1) begin
      fails++;
      $display("[TB] FAIL abort_idle: got busy/se/ready=%b ok=%0d%0d expected 000 11",
               {busy, scan_enable, byte_ready}, ok0, ok1);
    end
    tick();
    tick();
    checks++;
    if (rv_count - rv0 != 1 || done_count != d0) begin
      fails++;
      $display("[TB] FAIL abort_strobes: got rd=%0d done=%0d expected 1 0",
               rv_count - rv0, done_count - d0);
    end
    checks++;
    if (rd_data !== 8'h12) begin
      fails++;
      $display("[TB] FAIL abort_rd_data: got %h expected 12", rd_data);
    end
    // A fresh pass after the abort must run cleanly from the beginning.
    test_loopback_case("after_abort", 8'h5A, 8'hC3, 0);
  endtask

  task automatic test_start_ignored();
    int n0, d0;
    bit ok0, ok1, ok2;
    // start together with abort in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || byte_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL start_abort_idle: got busy=%b ready=%b expected 0 0",
               busy, byte_ready);
    end
    preset_chain(16'h1234);
    n0 = rd_log.size();
    d0 = done_count;
    pulse_start();
    pulse_start();
    checks++;
    if (byte_ready !== 1'b1 || scan_enable !== 1'b0) begin
      fails++;
      $display("[TB] FAIL start_in_wait: got ready=%b se=%b expected 1 0",
               byte_ready, scan_enable);
    end
    send_byte(8'hFF, ok0);
    tick();
    pulse_start();
    send_byte(8'h00, ok1);
    wait_done(ok2);
    checks++;
    if (!(ok0 && ok1 && ok2) || chain !== 16'hFF00 || done_count - d0 != 1) begin
      fails++;
      $display("[TB] FAIL start_busy_load: got chain=%h done=%0d ok=%0d%0d%0d expected ff00 1 111",
               chain, done_count - d0, ok0, ok1, ok2);
    end
    checks++;
    if (rd_log.size() < n0 + 2 || rd_log[n0] !== 8'h12 || rd_log[n0+1] !== 8'h34) begin
      fails++;
      $display("[TB] FAIL start_busy_rd: got %p expected 12 34", rd_log);
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || byte_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL start_no_restart: got busy=%b ready=%b expected 0 0",
               busy, byte_ready);
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    test_reset();
    test_loopback();
    test_stall();
    test_abort();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
